// File: rtl/mips_mmio_uart_tx.sv
// Data-side bus slave for the single-cycle MIPS core: decodes a small I/O window
// holding a FIFO-buffered UART transmitter and passes every other access to data RAM.
module mips_mmio_uart_tx #(
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter logic [15:0] BAUD_DIV_RST = 16'd433,
    parameter logic [31:0] IO_BASE      = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        ram_we,
    input  logic [31:0] ram_rdata,
    output logic        txd,
    output logic        tx_irq
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned BW = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, wr_ptr_n;
    logic [PW-1:0]   rd_ptr, rd_ptr_n;
    logic [CW-1:0]   count, count_n;
    logic            overflow, overflow_n;
    logic [BW-1:0]   bauddiv, bauddiv_n;
    logic [BW-1:0]   bit_cnt, bit_cnt_n;
    logic [7:0]      shift, shift_n;
    logic [2:0]      idx, idx_n;
    logic            txd_n, tx_irq_n;

    logic            win_hit;
    logic [1:0]      offs;
    logic            wr_txdata, wr_status, wr_baud;
    logic            full, empty, busy;
    logic            push, pop;
    logic [31:0]     status;
    logic [31:0]     io_rdata;
    logic            unused_bits;

    // Window decode; byte lanes within a word are not distinguished
    assign win_hit   = (aluout[31:4] == IO_BASE[31:4]);
    assign offs      = aluout[3:2];
    assign wr_txdata = memwrite && win_hit && (offs == 2'd0);
    assign wr_status = memwrite && win_hit && (offs == 2'd1);
    assign wr_baud   = memwrite && win_hit && (offs == 2'd2);

    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign busy  = (state != IDLE);
    assign push  = wr_txdata && !full;
    assign pop   = (state == IDLE) && !empty;

    assign status      = {28'd0, overflow, busy, empty, full};
    assign unused_bits = ^{aluout[1:0], writedata[31:16]};

    // Combinational load path and RAM write steering
    always_comb begin
        io_rdata = '0;
        case (offs)
            2'd1:    io_rdata = status;
            2'd2:    io_rdata = {16'd0, bauddiv};
            default: io_rdata = '0;
        endcase
        readdata = win_hit ? io_rdata : ram_rdata;
        ram_we   = memwrite && !win_hit;
    end

    // FIFO storage; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= writedata[7:0];
        end
    end

    // FIFO bookkeeping and control registers
    always_comb begin
        wr_ptr_n   = wr_ptr;
        rd_ptr_n   = rd_ptr;
        overflow_n = overflow;
        bauddiv_n  = bauddiv;
        if (push) begin
            wr_ptr_n = wr_ptr + PW'(1);
        end
        if (pop) begin
            rd_ptr_n = rd_ptr + PW'(1);
        end
        count_n = count + CW'(push) - CW'(pop);
        if (wr_status && writedata[3]) begin
            overflow_n = 1'b0;
        end
        if (wr_txdata && full) begin
            overflow_n = 1'b1;
        end
        if (wr_baud) begin
            bauddiv_n = writedata[15:0];
        end
    end

    // TX framing FSM: next state, bit timing and the registered line values
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        idx_n     = idx;
        shift_n   = shift;
        case (state)
            IDLE: begin
                if (!empty) begin
                    shift_n   = mem[rd_ptr];
                    bit_cnt_n = bauddiv;
                    state_n   = START;
                end
            end
            START: begin
                if (bit_cnt == '0) begin
                    state_n   = DATA;
                    idx_n     = 3'd0;
                    bit_cnt_n = bauddiv;
                end else begin
                    bit_cnt_n = bit_cnt - BW'(1);
                end
            end
            DATA: begin
                if (bit_cnt == '0) begin
                    bit_cnt_n = bauddiv;
                    if (idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end else begin
                    bit_cnt_n = bit_cnt - BW'(1);
                end
            end
            STOP: begin
                if (bit_cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    bit_cnt_n = bit_cnt - BW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // Line level and interrupt follow the next state so both come straight from flops
        case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = shift_n[idx_n];
            default: txd_n = 1'b1;
        endcase
        tx_irq_n = (count_n == '0) && (state_n == IDLE);
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            bauddiv  <= BAUD_DIV_RST;
            bit_cnt  <= '0;
            shift    <= '0;
            idx      <= '0;
            txd      <= 1'b1;
            tx_irq   <= 1'b1;
        end else begin
            state    <= state_n;
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            count    <= count_n;
            overflow <= overflow_n;
            bauddiv  <= bauddiv_n;
            bit_cnt  <= bit_cnt_n;
            shift    <= shift_n;
            idx      <= idx_n;
            txd      <= txd_n;
            tx_irq   <= tx_irq_n;
        end
    end

endmodule

// File: tb/tb_mips_mmio_uart_tx.sv
// Bench for mips_mmio_uart_tx: directed bus sequences with random payloads, the
// serial line compared cycle by cycle against waveforms built from frame arithmetic.
module tb_mips_mmio_uart_tx;

    localparam logic [31:0] A_TX = 32'hFFFF_0000;
    localparam logic [31:0] A_ST = 32'hFFFF_0004;
    localparam logic [31:0] A_BD = 32'hFFFF_0008;
    localparam logic [31:0] A_RS = 32'hFFFF_000C;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        memwrite  = 1'b0;
    logic [31:0] aluout    = 32'h0;
    logic [31:0] writedata = 32'h0;
    logic [31:0] ram_rdata = 32'h0;
    logic [31:0] readdata;
    logic        ram_we;
    logic        txd;
    logic        tx_irq;

    int passed = 0;
    int total  = 0;

    bit   capq[$];
    bit   irqq[$];
    bit   expq[$];
    bit   cap_en = 1'b0;

    mips_mmio_uart_tx dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .aluout    (aluout),
        .writedata (writedata),
        .readdata  (readdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .txd       (txd),
        .tx_irq    (tx_irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cap_en) begin
            capq.push_back(txd);
            irqq.push_back(tx_irq);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        aluout    = a;
        writedata = d;
        tick();
        memwrite  = 1'b0;
        aluout    = 32'h0;
        writedata = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        aluout = a;
        #1;
        d = readdata;
        aluout = 32'h0;
    endtask

    task automatic check_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    function automatic void push_level(input bit v, input int n);
        repeat (n) expq.push_back(v);
    endfunction

    // One UART frame: start bit, 8 data bits LSB first, stop bit
    function automatic void push_frame(input logic [7:0] b, input int ps, input int pb);
        push_level(1'b0, ps);
        for (int i = 0; i < 8; i++) push_level(b[i], pb);
        push_level(1'b1, pb);
    endfunction

    // Called one cycle before the first TXDATA write edge: two idle samples precede the frame
    task automatic start_capture();
        capq.delete();
        irqq.delete();
        expq.delete();
        cap_en = 1'b1;
        push_level(1'b1, 2);
    endtask

    task automatic finish_capture(input string tag);
        for (int i = 0; i < 20000 && capq.size() < expq.size(); i++) tick();
        cap_en = 1'b0;
        check({tag, "_len"}, 32'(capq.size() >= expq.size()), 32'd1);
        for (int i = 0; i < expq.size() && i < capq.size(); i++)
            check($sformatf("%s_txd[%0d]", tag, i), 32'(capq[i]), 32'(expq[i]));
    endtask

    initial begin
        logic [7:0] b [10];
        int         p;
        logic [31:0] r;

        // Reset and pass-through
        #1 reset = 1'b0;
        tick(3);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_irq", 32'(tx_irq), 32'd1);
        ram_rdata = 32'hDEADBEEF;
        memwrite  = 1'b1;
        aluout    = 32'h0000_0040;
        #1;
        check("rst_ram_we", 32'(ram_we), 32'd1);
        check("rst_rdata", readdata, 32'hDEADBEEF);
        memwrite = 1'b0;
        aluout   = 32'h0;
        reset    = 1'b1;
        tick();
        check_read("status_after_rst", A_ST, 32'h2);
        check_read("status_lane_ignored", 32'hFFFF_0006, 32'h2);
        check_read("baud_rst", A_BD, 32'h1B1);
        check_read("txdata_reads_zero", A_TX, 32'h0);
        check_read("reserved_reads_zero", A_RS, 32'h0);
        memwrite = 1'b1;
        aluout   = 32'h0000_0040;
        #1;
        check("miss_ram_we", 32'(ram_we), 32'd1);
        check("miss_rdata", readdata, 32'hDEADBEEF);
        ram_rdata = $urandom;
        aluout    = 32'hFFFF_0010;
        #1;
        check("above_win_ram_we", 32'(ram_we), 32'd1);
        check("above_win_rdata", readdata, ram_rdata);
        aluout = 32'hFFFE_FFFC;
        #1;
        check("below_win_ram_we", 32'(ram_we), 32'd1);
        aluout = A_ST;
        #1;
        check("hit_ram_we", 32'(ram_we), 32'd0);
        memwrite = 1'b0;
        ram_rdata = $urandom;
        aluout = 32'h0000_1000;
        #1;
        check("miss_rd_ram_we", 32'(ram_we), 32'd0);
        check("miss_rd_rdata", readdata, ram_rdata);
        aluout = 32'h0;

        // Single frame 0xA5 at BAUDDIV = 3
        bus_write(A_BD, 32'h3);
        check_read("baud_3", A_BD, 32'h3);
        start_capture();
        push_frame(8'hA5, 4, 4);
        push_level(1'b1, 20);
        bus_write(A_TX, 32'hA5);
        tick(2);
        check_read("single_status_busy", A_ST, 32'h6);
        check("single_irq_low", 32'(tx_irq), 32'd0);
        finish_capture("single");
        for (int i = 0; i < irqq.size(); i++)
            check($sformatf("single_irq[%0d]", i), 32'(irqq[i]), 32'((i == 0) || (i >= 42)));
        check_read("single_status_done", A_ST, 32'h2);

        // Back-to-back 0x55, 0x0F
        start_capture();
        push_frame(8'h55, 4, 4);
        push_level(1'b1, 1);
        push_frame(8'h0F, 4, 4);
        push_level(1'b1, 20);
        bus_write(A_TX, 32'h55);
        bus_write(A_TX, 32'h0F);
        finish_capture("b2b");
        check_read("b2b_status", A_ST, 32'h2);

        // Random bytes back-to-back at a random short divider, including 0
        p = int'($urandom_range(0, 5));
        bus_write(A_BD, 32'(p));
        for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
        start_capture();
        for (int i = 0; i < 4; i++) begin
            push_frame(b[i], p + 1, p + 1);
            if (i < 3) push_level(1'b1, 1);
        end
        push_level(1'b1, 20);
        for (int i = 0; i < 4; i++) bus_write(A_TX, {24'($urandom), b[i]});
        finish_capture("rnd");

        // Full / overflow at BAUDDIV = 100
        bus_write(A_BD, 32'd100);
        for (int i = 0; i < 10; i++) b[i] = 8'($urandom);
        start_capture();
        for (int i = 0; i < 9; i++) begin
            push_frame(b[i], 101, 101);
            if (i < 8) push_level(1'b1, 1);
        end
        push_level(1'b1, 20);
        for (int i = 0; i < 10; i++) bus_write(A_TX, {24'h0, b[i]});
        check_read("ovf_status", A_ST, 32'h0D);
        check("ovf_irq", 32'(tx_irq), 32'd0);
        bus_write(A_ST, 32'h7);
        check_read("ovf_sticky", A_ST, 32'h0D);
        bus_write(A_ST, 32'h8);
        check_read("ovf_cleared", A_ST, 32'h05);
        bus_write(A_RS, 32'hFFFF_FFFF);
        check_read("reserved_ignored_baud", A_BD, 32'd100);
        check_read("reserved_ignored_status", A_ST, 32'h05);
        finish_capture("ovf");
        check_read("ovf_drained", A_ST, 32'h2);

        // Divider change during the start bit
        bus_write(A_BD, 32'd7);
        b[0] = 8'($urandom);
        start_capture();
        push_frame(b[0], 8, 2);
        push_level(1'b1, 20);
        bus_write(A_TX, {24'h0, b[0]});
        bus_write(A_BD, 32'h0001_0001);
        check_read("baud_readback_1", A_BD, 32'h1);
        finish_capture("baudchg");

        // Asynchronous reset during data bit 3 with bytes queued
        bus_write(A_BD, 32'd3);
        b[0] = 8'($urandom) & 8'hF7;
        b[1] = 8'($urandom);
        b[2] = 8'($urandom);
        for (int i = 0; i < 3; i++) bus_write(A_TX, {24'h0, b[i]});
        tick(16);
        check("pre_rst_bit3", 32'(txd), 32'd0);
        check_read("pre_rst_status", A_ST, 32'h4);
        #1 reset = 1'b0;
        #1;
        check("async_rst_txd", 32'(txd), 32'd1);
        check("async_rst_irq", 32'(tx_irq), 32'd1);
        check_read("in_rst_status", A_ST, 32'h2);
        tick(2);
        reset = 1'b1;
        tick();
        check_read("post_rst_status", A_ST, 32'h2);
        check_read("post_rst_baud", A_BD, 32'h1B1);
        start_capture();
        push_level(1'b1, 150);
        finish_capture("post_rst_idle");
        r = 32'(tx_irq);
        check("post_rst_irq", r, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mips_mmio_uart_tx.md
Name: mips_mmio_uart_tx

Overview:
- Data-side bus slave that sits directly downstream of the single-cycle MIPS core.
- Consumes the core's memwrite, aluout (address) and writedata, and produces the core's readdata.
- Decodes a small memory-mapped I/O window holding a UART transmitter with a TX FIFO. All other addresses pass through to the data RAM.
- Gives programs a serial console without stalling the core. Because the core is single-cycle, reads are combinational.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; power of two, at least 2.
- BAUD_DIV_RST, 433, reset value of BAUDDIV. Bit period is BAUDDIV+1 clocks, so 433 gives 115200 baud at 50 MHz.
- IO_BASE, 32'hFFFF_0000, base address of the I/O window.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- memwrite  in  1  store strobe from the core.
- aluout  in  32  byte address from the core.
- writedata  in  32  store data from the core.
- readdata  out  32  load data to the core; combinational.
- ram_we  out  1  write enable to the data RAM; combinational.
- ram_rdata  in  32  read data from the data RAM.
- txd  out  1  serial output; idles high.
- tx_irq  out  1  high while the FIFO is empty and the shifter is idle.

Behaviour:
- Address decode:
  - The I/O window is hit when aluout[31:4] == IO_BASE[31:4]. aluout[1:0] are ignored.
  - Offsets: 0x0 TXDATA (write-only; reads return 0). 0x4 STATUS. 0x8 BAUDDIV (16-bit, read/write, upper bits read as 0). 0xC reserved (reads 0, writes ignored).
  - STATUS bits: bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits[31:4] = 0.
  - On a window miss: ram_we = memwrite and readdata = ram_rdata.
  - On a window hit: ram_we = 0 and readdata = the selected register.
- Writes take effect on the rising edge where memwrite = 1.
  - TXDATA: pushes writedata[7:0] if the FIFO is not full at that edge. If full, the byte is dropped and overflow is set. A pop on the same edge does not rescue the push.
  - STATUS: writing bit3 = 1 clears overflow. If an overflow occurs on the same edge, set wins.
  - BAUDDIV: loads writedata[15:0]. The new value is used at the next bit-counter reload; the bit currently being sent is not shortened or lengthened.
- FIFO:
  - Circular, with read/write pointers that wrap modulo FIFO_DEPTH and a count of 0..FIFO_DEPTH.
  - full = (count == FIFO_DEPTH); empty = (count == 0).
  - A simultaneous push and pop when not full and not empty leaves count unchanged.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd = 1. If the FIFO is non-empty, pop the head into the shift register, load the bit counter with BAUDDIV, go to START.
  - START: txd = 0 for BAUDDIV+1 clocks, then go to DATA with bit index 0.
  - DATA: txd = shift[idx], LSB first, each bit held BAUDDIV+1 clocks. After idx 7, go to STOP.
  - STOP: txd = 1 for BAUDDIV+1 clocks. Then go to IDLE. IDLE pops on the following edge if data is waiting, so back-to-back frames have exactly a one-clock extra high gap.
  - Latency: a TXDATA write at edge N into an empty FIFO while IDLE makes the FSM pop at edge N+1 and drive txd low starting after edge N+1.
- tx_irq = empty && state == IDLE; registered-state derived, glitch-free.
- Reset (reset = 0, asynchronous, at any time including mid-frame):
  - txd = 1, state = IDLE, FIFO pointers and count = 0, overflow = 0, BAUDDIV = BAUD_DIV_RST, shift register and counters = 0, tx_irq = 1.
  - readdata and ram_we stay combinational from their inputs during reset.
  - A partially sent frame is abandoned; no resume after reset release.

Test Plan:
- Reset and pass-through: hold reset = 0, then release. Expect txd = 1, tx_irq = 1, STATUS read = 0x2. memwrite = 1 at aluout 0x0000_0040 gives ram_we = 1; readdata follows ram_rdata = 0xDEADBEEF.
- Single frame: BAUDDIV = 3, write 0xA5 to 0xFFFF_0000. Expect txd low one edge later, then bits 1,0,1,0,0,1,0,1, then stop high. Each bit lasts 4 clocks, 40 clocks per frame. busy = 1 throughout; tx_irq rises after STOP.
- Back-to-back: write 0x55 then 0x0F on consecutive cycles. Expect two frames separated by a stop bit plus exactly one extra idle clock, and no data loss.
- Full/overflow: BAUDDIV = 100, write 10 bytes with DEPTH = 8. The first pops immediately, so 9 are accepted and the 10th is dropped. Expect STATUS = 0x0D (full, busy, overflow). Write 0x8 to STATUS → overflow clears. Verify the transmitted bytes match the accepted sequence.
- BAUDDIV change mid-frame: start a frame at BAUDDIV = 7 and write BAUDDIV = 1 during the start bit. Expect the start bit to last 8 clocks and subsequent bits to last 2 clocks. Readback of 0xFFFF_0008 returns 0x1.
- Reset mid-frame: assert reset during DATA bit 3 with 3 bytes queued. Expect txd = 1 immediately (asynchronously), STATUS = 0x2 after release, and no further frames.
